hex_byte_history: RTL and testbench

- Upstream feeder for the seven-segment hex decoders on HEX5..HEX0.
- Accepts a stream of bytes, such as keyboard scancodes or ASCII codes, over a valid/ready handshake.
- Keeps the most recent DEPTH bytes as a shift history and presents them as 2*DEPTH registered nibbles, one per decoder instance.
- Provides per-digit blank flags so unused digits stay dark, and an optional blink on the newest byte to mark fresh input.

---
 rtl/hex_byte_history.sv | 112 +++++++++++
 tb/tb_hex_byte_history.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/hex_byte_history.sv
// hex_byte_history: keeps the last DEPTH bytes of a valid/ready byte stream and
// presents them as registered nibbles with per-digit blank flags for a bank of
// seven-segment decoders. The newest byte can blink to mark fresh input.
module hex_byte_history #(
  parameter int DEPTH        = 3,
  parameter int BLINK_CYCLES = 25000000
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  input  logic [7:0]                   in_data,
  output logic                         in_ready,
  input  logic                         freeze,
  input  logic                         clear,
  input  logic                         blink_en,
  output logic [8*DEPTH-1:0]           digits,
  output logic [2*DEPTH-1:0]           digit_blank,
  output logic [$clog2(DEPTH+1)-1:0]   byte_count
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int TW = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
  localparam logic [TW-1:0] TMR_LAST  = TW'(BLINK_CYCLES - 1);
  localparam logic [CW-1:0] COUNT_MAX = CW'(DEPTH);

  // History entry 0 is the newest byte; entries at or beyond the count stay zero
  // because every flush zeroes them and shifting only ever moves data upward.
  logic [DEPTH-1:0][7:0] hist_r, hist_nxt;
  logic [CW-1:0]         count_r, count_nxt;
  logic [TW-1:0]         tmr_r, tmr_nxt;
  logic                  hidden_r, hidden_nxt;
  logic [2*DEPTH-1:0]    blank_r, blank_nxt;
  logic                  accept;

  assign in_ready    = ~freeze & ~clear;
  assign accept      = in_valid & in_ready;
  assign digits      = hist_r;
  assign byte_count  = count_r;
  assign digit_blank = blank_r;

  // Next-state selection with priority clear > freeze > accept > blink tick.
  always_comb begin
    hist_nxt   = hist_r;
    count_nxt  = count_r;
    tmr_nxt    = tmr_r;
    hidden_nxt = hidden_r;
    if (clear) begin
      hist_nxt   = '{default: 8'h00};
      count_nxt  = {CW{1'b0}};
      tmr_nxt    = {TW{1'b0}};
      hidden_nxt = 1'b0;
    end else if (freeze) begin
      hist_nxt   = hist_r;
    end else if (accept) begin
      hist_nxt[0] = in_data;
      for (int k = 1; k < DEPTH; k++) begin
        hist_nxt[k] = hist_r[k-1];
      end
      if (count_r == COUNT_MAX) begin
        count_nxt = count_r;
      end else begin
        count_nxt = count_r + CW'(1);
      end
      // Fresh byte always starts a full visible half-period.
      tmr_nxt    = {TW{1'b0}};
      hidden_nxt = 1'b0;
    end else begin
      if (tmr_r == TMR_LAST) begin
        tmr_nxt    = {TW{1'b0}};
        hidden_nxt = ~hidden_r;
      end else begin
        tmr_nxt    = tmr_r + TW'(1);
        hidden_nxt = hidden_r;
      end
    end
  end

  // Blank flags derived from the post-edge count and phase so they line up with digits.
  always_comb begin
    blank_nxt = {(2*DEPTH){1'b1}};
    for (int k = 0; k < DEPTH; k++) begin
      if (CW'(k) >= count_nxt) begin
        blank_nxt[2*k +: 2] = 2'b11;
      end else begin
        blank_nxt[2*k +: 2] = 2'b00;
      end
    end
    if (blink_en && (count_nxt != {CW{1'b0}}) && hidden_nxt) begin
      blank_nxt[1:0] = 2'b11;
    end else begin
      blank_nxt[1:0] = blank_nxt[1:0];
    end
  end

  // State and output registers; reset overrides everything else.
  always_ff @(posedge clk) begin
    if (reset) begin
      hist_r   <= '{default: 8'h00};
      count_r  <= {CW{1'b0}};
      tmr_r    <= {TW{1'b0}};
      hidden_r <= 1'b0;
      blank_r  <= {(2*DEPTH){1'b1}};
    end else begin
      hist_r   <= hist_nxt;
      count_r  <= count_nxt;
      tmr_r    <= tmr_nxt;
      hidden_r <= hidden_nxt;
      blank_r  <= blank_nxt;
    end
  end

endmodule

// File: tb/tb_hex_byte_history.sv
// Self-checking bench for hex_byte_history (DEPTH=3, BLINK_CYCLES=4).
// Each cycle's expected outputs are queued when the stimulus is driven and
// compared after the following rising edge.
module tb_hex_byte_history;

  logic        clk = 1'b0;
  logic        reset, in_valid, freeze, clear, blink_en;
  logic [7:0]  in_data;
  logic        in_ready;
  logic [23:0] digits;
  logic [5:0]  digit_blank;
  logic [1:0]  byte_count;

  int compared   = 0;
  int mismatched = 0;
  int step_no    = 0;

  typedef struct {
    logic [23:0] d;
    logic [5:0]  b;
    logic [1:0]  c;
  } exp_t;

  typedef struct {
    logic        rst, valid, frz, clr, ben;
    logic [7:0]  data;
    logic [23:0] d;
    logic [5:0]  b;
    logic [1:0]  c;
  } vec_t;

  exp_t exp_q[$];
  vec_t tbl[12];

  hex_byte_history #(.DEPTH(3), .BLINK_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .freeze(freeze), .clear(clear), .blink_en(blink_en),
    .digits(digits), .digit_blank(digit_blank), .byte_count(byte_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    compared++;
    if (act !== want) begin
      mismatched++;
      $display("FAIL %s at step %0d: got %h, want %h", name, step_no, act, want);
    end
  endtask

  task automatic step(input logic rst, input logic valid, input logic frz, input logic clr,
                      input logic ben, input logic [7:0] data,
                      input logic [23:0] d, input logic [5:0] b, input logic [1:0] c);
    exp_t e;
    exp_t got;
    @(negedge clk);
    reset = rst; in_valid = valid; freeze = frz; clear = clr; blink_en = ben; in_data = data;
    #1;
    chk("in_ready", {31'd0, in_ready}, {31'd0, ~(frz | clr)});
    e.d = d; e.b = b; e.c = c;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    got = exp_q.pop_front();
    chk("digits", {8'd0, digits}, {8'd0, got.d});
    chk("digit_blank", {26'd0, digit_blank}, {26'd0, got.b});
    chk("byte_count", {30'd0, byte_count}, {30'd0, got.c});
    step_no++;
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; freeze = 1'b0; clear = 1'b0; blink_en = 1'b0; in_data = 8'h00;

    //          rst   valid frz   clr   ben   data    digits      blank  count
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 24'h000000, 6'h3F, 2'd0};
    tbl[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h1C, 24'h00001C, 6'h3C, 2'd1};
    tbl[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h32, 24'h001C32, 6'h30, 2'd2};
    tbl[3]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h23, 24'h1C3223, 6'h00, 2'd3};
    tbl[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h2B, 24'h32232B, 6'h00, 2'd3};
    tbl[5]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h41, 24'h32232B, 6'h00, 2'd3};
    tbl[6]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h41, 24'h32232B, 6'h00, 2'd3};
    tbl[7]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h41, 24'h232B41, 6'h00, 2'd3};
    tbl[8]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h66, 24'h000000, 6'h3F, 2'd0};
    tbl[9]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h66, 24'h000066, 6'h3C, 2'd1};
    tbl[10] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h66, 24'h000000, 6'h3F, 2'd0};
    tbl[11] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h5A, 24'h00005A, 6'h3C, 2'd1};

    // Reset, then 10 idle cycles hold the reset state.
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 24'h000000, 6'h3F, 2'd0);
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 24'h000000, 6'h3F, 2'd0);
    end

    // Table: fill, saturate, freeze, clear beats valid, reset beats clear.
    for (int i = 0; i < 12; i++) begin
      step(tbl[i].rst, tbl[i].valid, tbl[i].frz, tbl[i].clr, tbl[i].ben, tbl[i].data,
           tbl[i].d, tbl[i].b, tbl[i].c);
    end

    // Blink: fresh reset, accept 0x5A with blink on, 4 visible / 4 hidden / 4 visible.
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 24'h000000, 6'h3F, 2'd0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h5A, 24'h00005A, 6'h3C, 2'd1);
    for (int i = 1; i < 13; i++) begin
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 24'h00005A,
           (((i / 4) % 2) == 1) ? 6'h3F : 6'h3C, 2'd1);
    end
    // Hidden phase, blink disabled: newest byte shows on the next cycle.
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 24'h00005A, 6'h3C, 2'd1);
    // Accept mid-hidden forces visible.
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h77, 24'h005A77, 6'h30, 2'd2);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 24'h005A77, 6'h30, 2'd2);
    end
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 24'h005A77, 6'h33, 2'd2);

    // Freeze in the hidden phase for 5 cycles: blink must not advance.
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'h41, 24'h005A77, 6'h33, 2'd2);
    end
    // Release: held byte taken on the first edge.
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h41, 24'h5A7741, 6'h00, 2'd3);

    // Accept on the wrap edge: phase forced visible, counter restarts.
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 24'h5A7741, 6'h00, 2'd3);
    end
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h99, 24'h774199, 6'h00, 2'd3);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 24'h774199, 6'h00, 2'd3);
    end
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 24'h774199, 6'h03, 2'd3);

    // Clear during hidden phase with a pending byte.
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'h66, 24'h000000, 6'h3F, 2'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
